// File: rtl/mips_dmem_pkg.sv
// Shared types and helpers for the MIPS data-memory responder.
// Optional bounds checking is enabled with DMEM_BOUNDS_CHECK_EN.
package mips_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmem_req_t;

  localparam logic [5:0] OP_LWD = 6'b001100;
  localparam logic [5:0] OP_STW = 6'b001101;

  function automatic logic [31:0] word_index(
    input logic [31:0] addr
  );
    return addr >> 2;
  endfunction

endpackage

// File: rtl/mips_dmem_array.sv
// Synchronous single-port word RAM with a registered read port.
// Storage and read register are intentionally not reset.
module mips_dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we)
      mem[index] <= wdata;
    if (en && !we)
      rdata <= mem[index];
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MEM stage: valid/ready, fixed latency.
// Define DMEM_BOUNDS_CHECK_EN for rsp_err reporting and err_cnt.
module mips_dmem_responder
  import mips_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  dmem_state_e      state_q, state_d;
  dmem_req_t        hold_q, hold_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             rdy_q;
  logic             ram_en;
  logic [31:0]      ram_rdata;
  logic [31:0]      widx;
  logic [IDX_W-1:0] idx;
  logic             bad;
  logic             access;

  assign widx = word_index(hold_q.addr);
  assign idx  = widx[IDX_W-1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign bad = (|hold_q.addr[1:0]) ||
               (widx >= 32'(DEPTH_WORDS));
`else
  logic unused_bits;
  assign bad         = 1'b0;
  assign unused_bits = ^{widx[31:IDX_W],
                         hold_q.addr[1:0]};
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    ram_en    = 1'b0;
    access    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = rdy_q;
        if (req_valid && rdy_q) begin
          hold_d.we    = req_we;
          hold_d.addr  = 32'(req_addr);
          hold_d.wdata = req_wdata;
          cnt_d        = LAT_M1;
          state_d      = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          ram_en  = !bad;
          err_d   = bad;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  // RAM read register holds its value until the next enabled read
  assign rsp_rdata = (state_q == RESP && !hold_q.we && !err_q)
                     ? ram_rdata : 32'd0;

`ifdef DMEM_BOUNDS_CHECK_EN
  assign rsp_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= 8'd0;
    else if (access && bad && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`else
  logic unused_access;
  assign rsp_err       = 1'b0;
  assign unused_access = access;
`endif

  mips_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .en   (ram_en),
    .we   (hold_q.we),
    .index(idx),
    .wdata(hold_q.wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed self-checking bench for mips_dmem_responder.
// Bounds scenario runs only when DMEM_BOUNDS_CHECK_EN is defined.
module tb_mips_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY(LAT),
    .ADDR_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  // Issue one request; returns edges from accept to rsp_valid.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat,
                       output logic [31:0] rd, output logic er);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wd;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = ~we;
    req_addr = 32'hFFFF_FFFC;
    req_wdata = 32'hBAD0_BAD0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_rsp valid=%b rdata=%h exp 0/0",
               rsp_valid, rsp_rdata);
    end
    total++;
    if (req_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=0", req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] rd;
    logic er;
    issue(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    total++;
    if (lat !== LAT || rd !== 32'd0) begin
      bad++;
      $display("FAIL stw_rsp lat=%0d rdata=%h exp lat=%0d rdata=0",
               lat, rd, LAT);
    end
    finish_rsp();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL stw_done valid=%b ready=%b exp 0/1",
               rsp_valid, req_ready);
    end
    issue(1'b0, 32'h10, 32'h0, lat, rd, er);
    total++;
    if (lat !== LAT || rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL lwd_rsp lat=%0d rdata=%h exp lat=%0d rdata=deadbeef",
               lat, rd, LAT);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] rd;
    logic er;
    issue(1'b1, 32'h8, 32'hCAFEF00D, lat, rd, er);
    finish_rsp();
    rsp_ready = 1'b0;
    issue(1'b0, 32'h8, 32'h0, lat, rd, er);
    total++;
    if (lat !== LAT || rd !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL bp_first lat=%0d rdata=%h exp lat=%0d rdata=cafef00d",
               lat, rd, LAT);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D ||
          req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d valid=%b rdata=%h ready=%b exp 1/cafef00d/0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    finish_rsp();
    total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'd0) begin
      bad++;
      $display("FAIL bp_release valid=%b rdata=%h exp 0/0",
               rsp_valid, rsp_rdata);
    end
  endtask

`ifndef DMEM_BOUNDS_CHECK_EN
  task automatic test_wrap();
    int lat;
    logic [31:0] rd;
    logic er;
    issue(1'b1, 32'(4 * DEPTH + 4), 32'h12345678, lat, rd, er);
    finish_rsp();
    issue(1'b0, 32'h4, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      bad++;
      $display("FAIL wrap_read rdata=%h err=%b exp 12345678/0", rd, er);
    end
    finish_rsp();
    issue(1'b0, 32'h7, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      bad++;
      $display("FAIL unaligned_read rdata=%h err=%b exp 12345678/0", rd, er);
    end
    finish_rsp();
  endtask
`else
  task automatic test_bounds();
    int lat;
    logic [31:0] rd;
    logic er;
    issue(1'b1, 32'h4, 32'h11112222, lat, rd, er);
    finish_rsp();
    issue(1'b1, 32'h6, 32'h0000FFFF, lat, rd, er);
    total++;
    if (er !== 1'b1 || err_cnt !== 8'd1 || lat !== LAT) begin
      bad++;
      $display("FAIL bounds_stw err=%b cnt=%0d lat=%0d exp 1/1/%0d",
               er, err_cnt, lat, LAT);
    end
    finish_rsp();
    issue(1'b0, 32'h4, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h11112222 || er !== 1'b0) begin
      bad++;
      $display("FAIL bounds_keep rdata=%h err=%b exp 11112222/0", rd, er);
    end
    finish_rsp();
    issue(1'b0, 32'(4 * DEPTH), 32'h0, lat, rd, er);
    total++;
    if (er !== 1'b1 || rd !== 32'd0 || err_cnt !== 8'd2) begin
      bad++;
      $display("FAIL bounds_lwd err=%b rdata=%h cnt=%0d exp 1/0/2",
               er, rd, err_cnt);
    end
    finish_rsp();
  endtask
`endif

  task automatic test_reset_mid_wait();
    int lat;
    int w;
    logic [31:0] rd;
    logic er;
    issue(1'b1, 32'h20, 32'h01020304, lat, rd, er);
    finish_rsp();
    w = 0;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'hA5A5A5A5;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_in_reset valid=%b exp=0", rsp_valid);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL abort_after%0d valid=%b exp=0", i, rsp_valid);
      end
    end
    issue(1'b0, 32'h20, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h01020304 || lat !== LAT) begin
      bad++;
      $display("FAIL abort_read rdata=%h lat=%0d exp 01020304/%0d",
               rd, lat, LAT);
    end
    finish_rsp();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
`ifndef DMEM_BOUNDS_CHECK_EN
    test_wrap();
`else
    test_bounds();
`endif
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
